// File: rtl/ahb_wdata_phase_mux.sv
// rtl/ahb_wdata_phase_mux.sv - AHB write-data phase multiplexer
// Captures the address-phase master select and steers that master's HWDATA during the data phase.
module ahb_wdata_phase_mux #(
  parameter int NUM_MASTERS = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 3,
  parameter int IDLE_HOLD   = 0
) (
  input  logic                              hclk,
  input  logic                              hresetn,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] hwdata_in,
  input  logic [SEL_WIDTH-1:0]              addr_sel,
  input  logic                              addr_valid,
  input  logic                              hready,
  output logic [DATA_WIDTH-1:0]             hwdata,
  output logic [SEL_WIDTH-1:0]              data_sel,
  output logic                              data_valid,
  output logic                              sel_err
);

  localparam logic [SEL_WIDTH:0] NUM_M = (SEL_WIDTH+1)'(NUM_MASTERS);

  logic [SEL_WIDTH-1:0]  data_sel_q, data_sel_d;
  logic                  data_valid_q, data_valid_d;
  logic                  sel_err_q, sel_err_d;
  logic                  sel_oor;
  logic [DATA_WIDTH-1:0] chan_data;
  logic [DATA_WIDTH-1:0] idle_data;

  assign sel_oor = ({1'b0, addr_sel} >= NUM_M);

  // A wait state freezes the pipeline; sel_err is a pulse, so it never holds.
  always_comb begin
    data_sel_d   = data_sel_q;
    data_valid_d = data_valid_q;
    sel_err_d    = 1'b0;
    if (hready) begin
      data_valid_d = addr_valid;
      data_sel_d   = (addr_valid && sel_oor) ? '0 : addr_sel;
      sel_err_d    = addr_valid && sel_oor;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      data_sel_q   <= '0;
      data_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      data_sel_q   <= data_sel_d;
      data_valid_q <= data_valid_d;
      sel_err_q    <= sel_err_d;
    end
  end

  always_comb begin
    chan_data = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (data_sel_q == SEL_WIDTH'(k)) begin
        chan_data = hwdata_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    if (IDLE_HOLD != 0) begin : g_hold
      logic [DATA_WIDTH-1:0] hold_q, hold_d;

      // Snapshot taken on the edge that completes a write data phase.
      assign hold_d = (data_valid_q && hready) ? chan_data : hold_q;

      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
          hold_q <= '0;
        end else begin
          hold_q <= hold_d;
        end
      end

      assign idle_data = hold_q;
    end else begin : g_zero
      assign idle_data = '0;
    end
  endgenerate

  assign hwdata     = data_valid_q ? chan_data : idle_data;
  assign data_sel   = data_sel_q;
  assign data_valid = data_valid_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_ahb_wdata_phase_mux.sv
// tb/tb_ahb_wdata_phase_mux.sv - bench for ahb_wdata_phase_mux
// Drives both idle modes from shared inputs and compares against a transfer-level model.
module tb_ahb_wdata_phase_mux;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int SW = 3;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [N*DW-1:0] hwdata_in;
  logic [SW-1:0]   addr_sel;
  logic            addr_valid;
  logic            hready;

  logic [DW-1:0] hwdata_z, hwdata_h;
  logic [SW-1:0] data_sel_z, data_sel_h;
  logic          data_valid_z, data_valid_h;
  logic          sel_err_z, sel_err_h;

  ahb_wdata_phase_mux #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .IDLE_HOLD(0)) u_dut_zero (
    .hclk(hclk), .hresetn(hresetn), .hwdata_in(hwdata_in), .addr_sel(addr_sel),
    .addr_valid(addr_valid), .hready(hready), .hwdata(hwdata_z), .data_sel(data_sel_z),
    .data_valid(data_valid_z), .sel_err(sel_err_z)
  );

  ahb_wdata_phase_mux #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .IDLE_HOLD(1)) u_dut_hold (
    .hclk(hclk), .hresetn(hresetn), .hwdata_in(hwdata_in), .addr_sel(addr_sel),
    .addr_valid(addr_valid), .hready(hready), .hwdata(hwdata_h), .data_sel(data_sel_h),
    .data_valid(data_valid_h), .sel_err(sel_err_h)
  );

  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;

  // Transfer-level model: the write currently in its data phase, plus the last completed write.
  logic          m_active;
  int            m_owner;
  logic          m_err;
  logic [DW-1:0] m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] chan(input int k);
    return hwdata_in[k*DW +: DW];
  endfunction

  task automatic randomize_data();
    for (int k = 0; k < N; k++) hwdata_in[k*DW +: DW] = $urandom;
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] exp_z, exp_h;
    exp_z = m_active ? chan(m_owner) : '0;
    exp_h = m_active ? chan(m_owner) : m_last;
    check({tag, ".valid_z"}, 64'(data_valid_z), 64'(m_active));
    check({tag, ".valid_h"}, 64'(data_valid_h), 64'(m_active));
    check({tag, ".sel_z"},   64'(data_sel_z),   64'(m_owner));
    check({tag, ".sel_h"},   64'(data_sel_h),   64'(m_owner));
    check({tag, ".err_z"},   64'(sel_err_z),    64'(m_err));
    check({tag, ".err_h"},   64'(sel_err_h),    64'(m_err));
    check({tag, ".hw_z"},    64'(hwdata_z),     64'(exp_z));
    check({tag, ".hw_h"},    64'(hwdata_h),     64'(exp_h));
  endtask

  // One bus clock: present an address phase, predict, clock, then wiggle data to prove zero latency.
  task automatic cycle(input int sel, input bit valid, input bit rdy, input bit rand_data, input string tag);
    logic          n_active, n_err;
    int            n_owner;
    logic [DW-1:0] n_last;
    addr_sel   = SW'(sel);
    addr_valid = valid;
    hready     = rdy;
    n_active = m_active;
    n_owner  = m_owner;
    n_last   = m_last;
    n_err    = rdy && valid && (sel >= N);
    if (rdy) begin
      if (m_active) n_last = chan(m_owner);
      n_active = valid;
      n_owner  = (valid && sel >= N) ? 0 : sel;
    end
    @(posedge hclk);
    m_active = n_active;
    m_owner  = n_owner;
    m_err    = n_err;
    m_last   = n_last;
    #1;
    if (rand_data) randomize_data();
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_err    = 1'b0;
    m_last   = '0;
  endtask

  // Reset pulse placed between edges, released before the next edge.
  task automatic mid_reset(input string tag);
    #2;
    hresetn = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".hw_zero"}, 64'(hwdata_h), 64'h0);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    hresetn    = 1'b0;
    addr_sel   = '0;
    addr_valid = 1'b0;
    hready     = 1'b1;
    randomize_data();
    model_reset();
    repeat (2) @(posedge hclk);
    #2;
    check_outputs("reset");
    @(negedge hclk);
    hresetn = 1'b1;

    // Single capture of channel 2.
    hwdata_in[2*DW +: DW] = 32'hCAFE0002;
    cycle(2, 1'b1, 1'b1, 1'b0, "cap2");
    check("cap2.const", 64'(hwdata_z), 64'hCAFE0002);

    // Wait states must freeze the owner while addr_sel moves.
    cycle(1, 1'b1, 1'b1, 1'b1, "cap1");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'b1, 1'b0, 1'b1, "wait");
      check("wait.sel1", 64'(data_sel_z), 64'd1);
    end
    cycle(0, 1'b1, 1'b1, 1'b1, "release");
    check("release.sel0", 64'(data_sel_z), 64'd0);

    // Back-to-back owner changes without a bubble.
    cycle(1, 1'b1, 1'b1, 1'b1, "b2b1");
    cycle(2, 1'b1, 1'b1, 1'b1, "b2b2");
    cycle(3, 1'b1, 1'b1, 1'b1, "oor");
    check("oor.err", 64'(sel_err_z), 64'd1);
    check("oor.ch0", 64'(hwdata_z), 64'(chan(0)));
    cycle(7, 1'b0, 1'b1, 1'b1, "oor_idle");
    check("oor_idle.err", 64'(sel_err_z), 64'd0);

    // Idle behaviour in both modes after a known write.
    hwdata_in[2*DW +: DW] = 32'h12345678;
    cycle(2, 1'b1, 1'b1, 1'b0, "hold_cap");
    cycle(0, 1'b0, 1'b1, 1'b1, "hold_idle");
    check("hold.keep", 64'(hwdata_h), 64'h12345678);
    check("hold.zero", 64'(hwdata_z), 64'h0);
    cycle(1, 1'b0, 1'b0, 1'b1, "hold_idle2");

    // Reset in the middle of a data phase, then a clean capture.
    cycle(1, 1'b1, 1'b1, 1'b1, "pre_rst");
    mid_reset("mid_rst");
    cycle(2, 1'b1, 1'b1, 1'b1, "post_rst");

    for (int i = 0; i < 400; i++) begin
      cycle(int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 1'b1, "rand");
      if ($urandom_range(0, 59) == 0) mid_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
